// File: rtl/axi_lite_mem.sv
// rtl/axi_lite_mem.sv - AXI-lite style multi-lane word memory with write/read arbitration
module axi_lite_mem #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 32,
  parameter int LANES  = 4,
  parameter int DEPTH  = 1024,
  parameter int ARB_RR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [WORD_W*LANES-1:0]  wdata,
  input  logic [LANES-1:0]         wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_W-1:0]        araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [WORD_W*LANES-1:0]  rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  output logic                     rlast,
  input  logic                     rready
);

  localparam int DATA_W = WORD_W * LANES;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LANES_X = (ADDR_W+1)'(LANES);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bound is evaluated one bit wider than the address so addr+LANES cannot wrap.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] ax;
    ax = {1'b0, a};
    return ((ax % LANES_X) == '0) && ((ax + LANES_X) <= DEPTH_X);
  endfunction

  function automatic logic [IDX_W-1:0] lane_idx(input logic [ADDR_W-1:0] a, input int lane);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + (ADDR_W+1)'(lane);
    return s[IDX_W-1:0];
  endfunction

  logic [WORD_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_beat;
  logic              w_elig, r_elig, w_acc, r_acc;
  logic              w_ok, r_ok;
  logic              rr_read;

  assign w_ok   = in_range(awaddr);
  assign r_ok   = in_range(araddr);
  assign w_elig = awvalid & wvalid & (~bvalid | bready) & ~rst;
  assign r_elig = arvalid & (~rvalid | rready) & ~rst;

  always_comb begin
    w_acc = w_elig;
    r_acc = r_elig & ~w_elig;
    if ((ARB_RR != 0) && w_elig && r_elig && rr_read) begin
      w_acc = 1'b0;
      r_acc = 1'b1;
    end
  end

  assign awready = w_acc;
  assign wready  = w_acc;
  assign arready = r_acc;
  assign rlast   = rvalid;

  // Pointer names the side that lost the last contested cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_read <= 1'b0;
    end else if (w_elig && r_elig) begin
      rr_read <= w_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && w_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (wstrb[i]) begin
          mem[lane_idx(awaddr, i)] <= wdata[i*WORD_W +: WORD_W];
        end
      end
    end
  end

  always_comb begin
    rd_beat = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_beat[i*WORD_W +: WORD_W] = mem[lane_idx(araddr, i)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (w_acc) begin
      bvalid <= 1'b1;
      bresp  <= w_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bready) begin
      bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (r_acc) begin
      rvalid <= 1'b1;
      rdata  <= r_ok ? rd_beat : '0;
      rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_mem.sv
// tb/tb_axi_lite_mem.sv - directed self-checking bench for axi_lite_mem (fixed-priority and round-robin)
module tb_axi_lite_mem;

  logic         clk = 1'b0;
  logic         rst;
  logic [11:0]  awaddr, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [127:0] wdata;
  logic [3:0]   wstrb;

  logic         awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]   bresp, rresp;
  logic [127:0] rdata;
  logic         awready_rr, wready_rr, bvalid_rr, arready_rr, rvalid_rr, rlast_rr;
  logic [1:0]   bresp_rr, rresp_rr;
  logic [127:0] rdata_rr;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] D_INIT = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] D_STRB = {32'd4, 32'hAAAA_AAAA, 32'd2, 32'hAAAA_AAAA};
  localparam logic [127:0] D_1020 = {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
  localparam logic [127:0] D_12   = {32'h1212_0003, 32'h1212_0002, 32'h1212_0001, 32'h1212_0000};
  localparam logic [127:0] D_16   = {32'h1616_0003, 32'h1616_0002, 32'h1616_0001, 32'h1616_0000};
  localparam logic [127:0] D_20   = {32'h2020_0003, 32'h2020_0002, 32'h2020_0001, 32'h2020_0000};
  localparam logic [127:0] D_28   = {32'h2828_0003, 32'h2828_0002, 32'h2828_0001, 32'h2828_0000};

  axi_lite_mem #(.ARB_RR(0)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
  );

  axi_lite_mem #(.ARB_RR(1)) dut_rr (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready_rr),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_rr),
    .bresp(bresp_rr), .bvalid(bvalid_rr), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready_rr),
    .rdata(rdata_rr), .rresp(rresp_rr), .rvalid(rvalid_rr), .rlast(rlast_rr), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_beat(input logic [11:0] a, input logic [127:0] d, input logic [3:0] s,
                            output logic rdy, output logic bv, output logic [1:0] br);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    #1;
    rdy = awready;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    bv = bvalid; br = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic read_beat(input logic [11:0] a, output logic rdy, output logic rv,
                           output logic rl, output logic [127:0] rd, output logic [1:0] rr);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    #1;
    rdy = arready;
    tick();
    arvalid = 1'b0;
    rv = rvalid; rl = rlast; rd = rdata; rr = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; awaddr = 12'd0; araddr = 12'd0; wdata = '0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    #1;
    checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL reset_accepts got %b expected 000", {awready, wready, arready}); end
    tick();
    tick();
    checks++; if ({bvalid, rvalid, rlast} !== 3'b000) begin errors++; $display("FAIL reset_valids got %b expected 000", {bvalid, rvalid, rlast}); end
    checks++; if (rdata !== 128'd0) begin errors++; $display("FAIL reset_rdata got %h expected 0", rdata); end
    checks++; if ({bresp, rresp} !== 4'b0000) begin errors++; $display("FAIL reset_resp got %b expected 0000", {bresp, rresp}); end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read;
    logic rdy, bv, rv, rl; logic [1:0] resp; logic [127:0] d;
    write_beat(12'd8, D_INIT, 4'hF, rdy, bv, resp);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wr_awready got %b expected 1", rdy); end
    checks++; if ({bv, resp} !== 3'b100) begin errors++; $display("FAIL wr_bresp got %b expected 100", {bv, resp}); end
    read_beat(12'd8, rdy, rv, rl, d, resp);
    checks++; if ({rdy, rv, rl} !== 3'b111) begin errors++; $display("FAIL rd_handshake got %b expected 111", {rdy, rv, rl}); end
    checks++; if (d !== D_INIT) begin errors++; $display("FAIL rd_data got %h expected %h", d, D_INIT); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL rd_rresp got %b expected 00", resp); end
  endtask

  task automatic test_strobe;
    logic rdy, bv, rv, rl; logic [1:0] resp; logic [127:0] d;
    write_beat(12'd8, {32'hDEAD_BEEF, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 32'hAAAA_AAAA}, 4'b0101, rdy, bv, resp);
    read_beat(12'd8, rdy, rv, rl, d, resp);
    checks++; if (d !== D_STRB) begin errors++; $display("FAIL strb_data got %h expected %h", d, D_STRB); end
    write_beat(12'd8, {4{32'hFFFF_FFFF}}, 4'b0000, rdy, bv, resp);
    checks++; if ({rdy, bv, resp} !== 4'b1100) begin errors++; $display("FAIL strb0_bresp got %b expected 1100", {rdy, bv, resp}); end
    read_beat(12'd8, rdy, rv, rl, d, resp);
    checks++; if (d !== D_STRB) begin errors++; $display("FAIL strb0_data got %h expected %h", d, D_STRB); end
  endtask

  task automatic test_out_of_range;
    logic rdy, bv, rv, rl; logic [1:0] resp; logic [127:0] d;
    read_beat(12'd6, rdy, rv, rl, d, resp);
    checks++; if ({rdy, rv, resp} !== 4'b1110 || d !== 128'd0) begin errors++; $display("FAIL oor_misaligned got %b/%h expected 1110/0", {rdy, rv, resp}, d); end
    read_beat(12'd1022, rdy, rv, rl, d, resp);
    checks++; if (resp !== 2'b10 || d !== 128'd0) begin errors++; $display("FAIL oor_1022 got %b/%h expected 10/0", resp, d); end
    read_beat(12'd1024, rdy, rv, rl, d, resp);
    checks++; if (resp !== 2'b10 || d !== 128'd0) begin errors++; $display("FAIL oor_1024 got %b/%h expected 10/0", resp, d); end
    write_beat(12'd1020, D_1020, 4'hF, rdy, bv, resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL edge_1020_bresp got %b expected 00", resp); end
    write_beat(12'd1022, {4{32'h5555_5555}}, 4'hF, rdy, bv, resp);
    checks++; if ({rdy, bv, resp} !== 4'b1110) begin errors++; $display("FAIL oor_wr_bresp got %b expected 1110", {rdy, bv, resp}); end
    read_beat(12'd1020, rdy, rv, rl, d, resp);
    checks++; if (resp !== 2'b00 || d !== D_1020) begin errors++; $display("FAIL oor_wr_unchanged got %b/%h expected 00/%h", resp, d, D_1020); end
  endtask

  task automatic test_read_after_write;
    awaddr = 12'd12; wdata = D_12; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 12'd12; arvalid = 1'b1; rready = 1'b1;
    #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL raw_arready got %b expected 1", arready); end
    tick();
    checks++; if (rvalid !== 1'b1 || rdata !== D_12) begin errors++; $display("FAIL raw_data got %b/%h expected 1/%h", rvalid, rdata, D_12); end
    arvalid = 1'b0; bready = 1'b0;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic rdy, bv; logic [1:0] resp;
    write_beat(12'd16, D_16, 4'hF, rdy, bv, resp);
    write_beat(12'd20, D_20, 4'hF, rdy, bv, resp);
    araddr = 12'd16; arvalid = 1'b1; rready = 1'b0;
    #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL b2b_first_accept got %b expected 1", arready); end
    tick();
    araddr = 12'd20;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({rvalid, arready} !== 2'b10 || rdata !== D_16) begin errors++; $display("FAIL stall_hold_%0d got %b/%h expected 10/%h", k, {rvalid, arready}, rdata, D_16); end
      tick();
    end
    rready = 1'b1;
    #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL stall_release_accept got %b expected 1", arready); end
    tick();
    checks++; if (rvalid !== 1'b1 || rdata !== D_20) begin errors++; $display("FAIL b2b_second got %b/%h expected 1/%h", rvalid, rdata, D_20); end
    araddr = 12'd16;
    #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL b2b_stream_accept got %b expected 1", arready); end
    tick();
    checks++; if (rvalid !== 1'b1 || rdata !== D_16) begin errors++; $display("FAIL b2b_third got %b/%h expected 1/%h", rvalid, rdata, D_16); end
    arvalid = 1'b0;
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b expected 0", rvalid); end
    rready = 1'b0;
  endtask

  task automatic test_reset_pending;
    logic rdy, rv, rl; logic [1:0] resp; logic [127:0] d;
    awaddr = 12'd28; wdata = D_28; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 12'd8; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    #1;
    checks++; if ({bvalid, rvalid} !== 2'b11) begin errors++; $display("FAIL pend_before_rst got %b expected 11", {bvalid, rvalid}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bvalid, rvalid} !== 2'b00 || rdata !== 128'd0) begin errors++; $display("FAIL pend_dropped got %b/%h expected 00/0", {bvalid, rvalid}, rdata); end
    bready = 1'b1; rready = 1'b1;
    tick();
    checks++; if ({bvalid, rvalid} !== 2'b00) begin errors++; $display("FAIL pend_not_reissued got %b expected 00", {bvalid, rvalid}); end
    bready = 1'b0; rready = 1'b0;
    read_beat(12'd8, rdy, rv, rl, d, resp);
    checks++; if (d !== D_STRB) begin errors++; $display("FAIL storage_kept got %h expected %h", d, D_STRB); end
    read_beat(12'd28, rdy, rv, rl, d, resp);
    checks++; if (d !== D_28) begin errors++; $display("FAIL pre_rst_write got %h expected %h", d, D_28); end
  endtask

  task automatic test_arbitration;
    logic [1:0] exp_rr;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    awaddr = 12'd24; araddr = 12'd24; wdata = D_INIT; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_rr = (c % 2 == 0) ? 2'b10 : 2'b01;
      checks++; if ({awready, arready} !== 2'b10) begin errors++; $display("FAIL prio_grant_%0d got %b expected 10", c, {awready, arready}); end
      checks++; if ({awready_rr, arready_rr} !== exp_rr) begin errors++; $display("FAIL rr_grant_%0d got %b expected %b", c, {awready_rr, arready_rr}, exp_rr); end
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    tick();
    bready = 1'b0; rready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_out_of_range();
    test_read_after_write();
    test_back_to_back();
    test_reset_pending();
    test_arbitration();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem.md
AXI_LITE_MEM -- requirements
Module: axi_lite_mem

Interface
- REQ-001: Parameter ADDR_W, default 12, width of awaddr/araddr; the address is a word index.
- REQ-002: Parameter WORD_W, default 32, storage word width in bits.
- REQ-003: Parameter LANES, default 4, words per beat; DATA_W = WORD_W*LANES.
- REQ-004: Parameter DEPTH, default 1024, number of storage words; DEPTH <= 2^ADDR_W.
- REQ-005: Parameter ARB_RR, default 0; 0 = write has priority, 1 = round-robin between write and read.
- REQ-006: One clock and one reset; reset is synchronous and active-high.
- REQ-007: clk  in  1  clock; all state updates on its rising edge.
- REQ-008: rst  in  1  synchronous active-high reset.
- REQ-009: awaddr in ADDR_W, awvalid in 1, awready out 1  write address channel.
- REQ-010: wdata in DATA_W, wstrb in LANES, wvalid in 1, wready out 1  write data channel; wstrb[i] enables word lane i.
- REQ-011: bresp out 2, bvalid out 1, bready in 1  write response channel.
- REQ-012: araddr in ADDR_W, arvalid in 1, arready out 1  read address channel.
- REQ-013: rdata out DATA_W, rresp out 2, rvalid out 1, rlast out 1, rready in 1  read data channel.

Function
- REQ-014: Lane i of a beat maps to word addr+i; rdata[i*WORD_W +: WORD_W] holds word addr+i.
- REQ-015: A write is eligible when awvalid & wvalid & (~bvalid | bready) are all high; AW and W are always accepted together.
- REQ-016: A read is eligible when arvalid & (~rvalid | rready) are both high.
- REQ-017: awready = wready = write accept, and arready = read accept; all three are combinational and at most one accept occurs per cycle.
- REQ-018: With ARB_RR=0 and both requests eligible, the write is accepted and the read waits.
- REQ-019: With ARB_RR=1 and both requests eligible, the side not granted on the last contested cycle wins, with write first after reset; uncontested accepts do not change the pointer.
- REQ-020: A request is in range when addr is a multiple of LANES and addr+LANES <= DEPTH; the bound is computed at ADDR_W+1 bits so it cannot wrap.
- REQ-021: An accepted in-range write updates each word whose wstrb bit is 1 at the clock edge of acceptance; bresp=00 (OKAY).
- REQ-022: An accepted out-of-range write modifies no storage; bresp=10 (SLVERR).
- REQ-023: bvalid rises in the cycle after the write accept and stays high, with bresp stable, until bvalid & bready.
- REQ-024: An accepted read registers rdata and rresp on the accept edge; rvalid is high in the next cycle, so read latency is 1.
- REQ-025: An out-of-range read returns rdata=0 and rresp=10; an in-range read returns rresp=00.
- REQ-026: rdata and rresp stay stable while rvalid & ~rready.
- REQ-027: Back-to-back reads proceed at one beat per cycle while rready is held high, because a new accept is allowed in the cycle the old beat completes.
- REQ-028: rlast equals rvalid, since every transfer is a single beat.
- REQ-029: A read accepted the cycle after a write to the same words returns the newly written data.
- REQ-030: wstrb = 0 with an in-range address completes with OKAY and changes no storage.

Reset
- REQ-031: While rst is high: bvalid=0, rvalid=0, rdata=0, rresp=00, bresp=00, no accepts, no storage writes, and the round-robin pointer is set to write.
- REQ-032: Storage contents are not cleared by reset.
- REQ-033: Reset asserted while bvalid or rvalid is pending drops the response; the response is not reissued after reset.

Verification
- REQ-034: Write addr 8, wdata word values {4,3,2,1} on lanes 3..0, wstrb=1111, then read addr 8 -> bresp=00, then rvalid one cycle after arready with rdata words {4,3,2,1} and rresp=00.
- REQ-035: Write addr 8 with wstrb=0101, lanes 0 and 2 = AAAA_AAAA, after the REQ-034 contents -> read addr 8 returns lanes {4, AAAA_AAAA, 2, AAAA_AAAA} (lane3..0).
- REQ-036: Read addr 6 (misaligned) and read addr DEPTH-2 -> rresp=10 and rdata=0; write to addr 1022 with DEPTH=1024 -> bresp=10 and storage unchanged.
- REQ-037: ARB_RR=1 with awvalid, wvalid and arvalid held high for 4 cycles, bready and rready high -> grants alternate W, R, W, R; with ARB_RR=0 all 4 grants go to write.
- REQ-038: rready held low for 3 cycles with arvalid high -> arready=0 and rdata stable; raise rready -> the held beat completes and the next read is accepted in that same cycle.
- REQ-039: Assert rst for 1 cycle while bvalid=1 and rvalid=1 -> both are 0 the following cycle, and a read of a previously written address still returns the old data.
